// File: rtl/pinaipple_pkg.sv
// pinaipple_pkg: memory-map regions, region/response enums and the shared address decode helper
package pinaipple_pkg;
    typedef enum logic [2:0] {REG_RAM, REG_GPIO, REG_UART, REG_TIMER, REG_NONE} region_e;
    typedef enum logic {S_IDLE, S_ERR_RESP} resp_state_e;
    localparam logic [31:0] RAM_START   = 32'h0010_0000;
    localparam logic [31:0] RAM_SIZE    = 32'h0001_0000;
    localparam logic [31:0] RAM_MASK    = ~(RAM_SIZE - 32'd1);
    localparam logic [31:0] GPIO_START  = 32'h8000_0000;
    localparam logic [31:0] GPIO_SIZE   = 32'h0000_1000;
    localparam logic [31:0] GPIO_MASK   = ~(GPIO_SIZE - 32'd1);
    localparam logic [31:0] UART_START  = 32'h8000_1000;
    localparam logic [31:0] UART_SIZE   = 32'h0000_1000;
    localparam logic [31:0] UART_MASK   = ~(UART_SIZE - 32'd1);
    localparam logic [31:0] TIMER_START = 32'h8000_2000;
    localparam logic [31:0] TIMER_SIZE  = 32'h0000_1000;
    localparam logic [31:0] TIMER_MASK  = ~(TIMER_SIZE - 32'd1);

    function automatic region_e decode_region(input logic [31:0] addr);
        return ((addr & RAM_MASK) == RAM_START)     ? REG_RAM   :
               ((addr & GPIO_MASK) == GPIO_START)   ? REG_GPIO  :
               ((addr & UART_MASK) == UART_START)   ? REG_UART  :
               ((addr & TIMER_MASK) == TIMER_START) ? REG_TIMER : REG_NONE;
    endfunction
endpackage

// File: rtl/addr_decoder.sv
// addr_decoder: combinational core address to region lookup
module addr_decoder
    import pinaipple_pkg::*;
#(
    parameter int AddrWidth = 32
) (
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 mapped_o,
    output region_e              region_o
);
    assign region_o = decode_region(32'(addr_i));
    assign mapped_o = region_o != REG_NONE;
endmodule

// File: rtl/core_data_bridge.sv
// core_data_bridge: forwards mapped core data requests to the interconnect, tracks outstanding
// responses and answers unmapped requests locally with an in-order error response
module core_data_bridge
    import pinaipple_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   core_req_i,
    output logic                   core_gnt_o,
    input  logic [AddrWidth-1:0]   core_addr_i,
    input  logic                   core_we_i,
    input  logic [DataWidth/8-1:0] core_be_i,
    input  logic [DataWidth-1:0]   core_wdata_i,
    output logic                   core_rvalid_o,
    output logic [DataWidth-1:0]   core_rdata_o,
    output logic                   core_err_o,
    output logic                   net_req_valid_o,
    input  logic                   net_req_ready_i,
    output logic [AddrWidth-1:0]   net_tgt_addr_o,
    output logic                   net_wen_o,
    output logic [DataWidth/8-1:0] net_be_o,
    output logic [DataWidth-1:0]   net_wdata_o,
    input  logic                   net_resp_valid_i,
    output logic                   net_resp_ready_o,
    input  logic [DataWidth-1:0]   net_resp_rdata_i,
    output logic                   proto_err_o
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic                 mapped, idle, fwd_gnt, err_gnt, resp_acc;
    region_e              region;
    logic [CntW-1:0]      cnt_q, cnt_d;
    resp_state_e          state_q, state_d;
    logic                 rvalid_q, rvalid_d, proto_q, proto_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    addr_decoder #(.AddrWidth(AddrWidth)) u_dec (
        .addr_i  (core_addr_i),
        .mapped_o(mapped),
        .region_o(region)
    );

    // A pending error response blocks forwarding too, so the interconnect never sees an ungranted request
    assign idle            = state_q == S_IDLE;
    assign net_req_valid_o = core_req_i & mapped & (cnt_q < CntMax) & idle;
    assign fwd_gnt         = net_req_valid_o & net_req_ready_i;
    assign err_gnt         = core_req_i & (region == REG_NONE) & (cnt_q == '0) & idle;
    assign resp_acc        = net_resp_valid_i & (cnt_q != '0);
    assign core_gnt_o      = fwd_gnt | err_gnt;
    assign net_tgt_addr_o  = core_addr_i;
    assign net_wen_o       = core_we_i;
    assign net_be_o        = core_be_i;
    assign net_wdata_o     = core_wdata_i;
    assign net_resp_ready_o = 1'b1;
    assign core_rvalid_o   = rvalid_q;
    assign core_rdata_o    = rdata_q;
    assign core_err_o      = ~idle;
    assign proto_err_o     = proto_q;

    always_comb begin
        cnt_d    = cnt_q + CntW'(fwd_gnt) - CntW'(resp_acc);
        state_d  = (idle && err_gnt) ? S_ERR_RESP : S_IDLE;
        rvalid_d = resp_acc | err_gnt;
        rdata_d  = resp_acc ? net_resp_rdata_i : err_gnt ? '0 : rdata_q;
        proto_d  = proto_q | (net_resp_valid_i & (cnt_q == '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            proto_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            proto_q  <= proto_d;
        end
    end
endmodule

// File: tb/tb_core_data_bridge.sv
// tb_core_data_bridge: directed scenarios with a response scoreboard for core_data_bridge
module tb_core_data_bridge;
    logic        clk = 1'b0, rst_i = 1'b1;
    logic        core_req_i = 1'b0, core_we_i = 1'b0, core_gnt_o, core_rvalid_o, core_err_o;
    logic [31:0] core_addr_i = '0, core_wdata_i = '0, core_rdata_o;
    logic [3:0]  core_be_i = 4'hF, net_be_o;
    logic        net_req_valid_o, net_req_ready_i = 1'b1, net_wen_o;
    logic [31:0] net_tgt_addr_o, net_wdata_o, net_resp_rdata_i = '0;
    logic        net_resp_valid_i = 1'b0, net_resp_ready_o, proto_err_o;
    int          checks = 0, errors = 0;
    logic [32:0] sb[$];

    core_data_bridge #(.DataWidth(32), .AddrWidth(32), .MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
        .core_we_i(core_we_i), .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .net_req_valid_o(net_req_valid_o), .net_req_ready_i(net_req_ready_i),
        .net_tgt_addr_o(net_tgt_addr_o), .net_wen_o(net_wen_o), .net_be_o(net_be_o),
        .net_wdata_o(net_wdata_o), .net_resp_valid_i(net_resp_valid_i),
        .net_resp_ready_o(net_resp_ready_o), .net_resp_rdata_i(net_resp_rdata_i),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic [31:0] d, input bit expect_delivery);
        net_resp_valid_i = 1'b1;
        net_resp_rdata_i = d;
        if (expect_delivery) sb.push_back({1'b0, d});
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_i && core_rvalid_o) begin
            if (sb.size() == 0) chk("unexpected_rvalid", 32'(core_rvalid_o), 32'd0);
            else begin
                e = sb.pop_front();
                chk("sb_err", 32'(core_err_o), 32'(e[32]));
                chk("sb_rdata", core_rdata_o, e[31:0]);
            end
        end
    end

    initial begin
        @(negedge clk);
        chk("rst_rvalid", 32'(core_rvalid_o), 0);
        chk("rst_err", 32'(core_err_o), 0);
        chk("rst_rdata", core_rdata_o, 0);
        chk("rst_proto", 32'(proto_err_o), 0);
        chk("rst_gnt", 32'(core_gnt_o), 0);
        chk("resp_ready", 32'(net_resp_ready_o), 1);
        cyc(); rst_i = 1'b0;
        // single RAM read
        cyc(); core_req_i = 1'b1; core_addr_i = 32'h0010_0004;
        @(negedge clk);
        chk("rd_gnt", 32'(core_gnt_o), 1);
        chk("rd_nrv", 32'(net_req_valid_o), 1);
        chk("rd_addr", net_tgt_addr_o, 32'h0010_0004);
        chk("rd_wen", 32'(net_wen_o), 0);
        chk("rd_be", 32'(net_be_o), 32'hF);
        cyc(); core_req_i = 1'b0;
        cyc(); resp(32'hDEAD_BEEF, 1);
        @(negedge clk); chk("rd_rvalid_early", 32'(core_rvalid_o), 0);
        cyc(); net_resp_valid_i = 1'b0;
        @(negedge clk);
        chk("rd_rvalid", 32'(core_rvalid_o), 1);
        chk("rd_rdata", core_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", 32'(core_err_o), 0);
        cyc();
        @(negedge clk);
        chk("rd_rvalid_once", 32'(core_rvalid_o), 0);
        chk("rd_rdata_hold", core_rdata_o, 32'hDEAD_BEEF);
        // three back-to-back reads against a limit of two outstanding
        cyc(); core_req_i = 1'b1; core_addr_i = 32'h0010_0010;
        @(negedge clk); chk("b2b_gnt0", 32'(core_gnt_o), 1);
        cyc(); core_addr_i = 32'h0010_0014;
        @(negedge clk); chk("b2b_gnt1", 32'(core_gnt_o), 1);
        cyc(); core_addr_i = 32'h0010_0018;
        @(negedge clk); chk("b2b_full_gnt", 32'(core_gnt_o), 0); chk("b2b_full_nrv", 32'(net_req_valid_o), 0);
        cyc(); @(negedge clk); chk("b2b_stall3", 32'(core_gnt_o), 0);
        cyc(); @(negedge clk); chk("b2b_stall4", 32'(core_gnt_o), 0);
        cyc(); resp(32'h1111_1111, 1);
        @(negedge clk); chk("b2b_full_with_resp", 32'(core_gnt_o), 0);
        cyc(); resp(32'h2222_2222, 1);
        @(negedge clk); chk("b2b_gnt2", 32'(core_gnt_o), 1);
        cyc(); core_req_i = 1'b0; net_resp_valid_i = 1'b0;
        cyc(); resp(32'h3333_3333, 1);
        cyc(); net_resp_valid_i = 1'b0;
        cyc(); cyc();
        // unmapped write answered locally, blocking the following grant for one cycle
        cyc(); core_req_i = 1'b1; core_addr_i = 32'h9000_0000; core_we_i = 1'b1; core_wdata_i = 32'h1234;
        @(negedge clk);
        chk("unm_gnt", 32'(core_gnt_o), 1);
        chk("unm_nrv", 32'(net_req_valid_o), 0);
        sb.push_back({1'b1, 32'h0});
        cyc(); core_addr_i = 32'h8000_1004; core_we_i = 1'b0;
        @(negedge clk);
        chk("unm_rvalid", 32'(core_rvalid_o), 1);
        chk("unm_err", 32'(core_err_o), 1);
        chk("unm_rdata", core_rdata_o, 0);
        chk("err_blocks_gnt", 32'(core_gnt_o), 0);
        cyc(); @(negedge clk);
        chk("uart_gnt", 32'(core_gnt_o), 1);
        chk("uart_nrv", 32'(net_req_valid_o), 1);
        cyc(); core_req_i = 1'b0;
        cyc(); resp(32'h0000_AAAA, 1);
        cyc(); net_resp_valid_i = 1'b0;
        cyc();
        // unmapped request waits behind an outstanding GPIO read
        cyc(); core_req_i = 1'b1; core_addr_i = 32'h8000_0000;
        @(negedge clk); chk("gpio_gnt", 32'(core_gnt_o), 1);
        cyc(); core_addr_i = 32'h0;
        @(negedge clk); chk("unm_stall0", 32'(core_gnt_o), 0); chk("unm_stall_nrv", 32'(net_req_valid_o), 0);
        cyc(); @(negedge clk); chk("unm_stall1", 32'(core_gnt_o), 0);
        cyc(); resp(32'h0000_0055, 1);
        @(negedge clk); chk("unm_stall_resp", 32'(core_gnt_o), 0);
        cyc(); net_resp_valid_i = 1'b0;
        @(negedge clk);
        chk("unm_after_gnt", 32'(core_gnt_o), 1);
        chk("gpio_rvalid", 32'(core_rvalid_o), 1);
        chk("gpio_err", 32'(core_err_o), 0);
        sb.push_back({1'b1, 32'h0});
        cyc(); core_req_i = 1'b0;
        @(negedge clk); chk("unm2_rvalid", 32'(core_rvalid_o), 1); chk("unm2_err", 32'(core_err_o), 1);
        cyc();
        // stray response with nothing outstanding
        cyc(); resp(32'h0000_0077, 0);
        @(negedge clk); chk("proto_pre", 32'(proto_err_o), 0);
        cyc(); net_resp_valid_i = 1'b0;
        @(negedge clk); chk("proto_set", 32'(proto_err_o), 1); chk("stray_rvalid", 32'(core_rvalid_o), 0);
        cyc(); cyc();
        @(negedge clk); chk("proto_hold", 32'(proto_err_o), 1);
        cyc(); rst_i = 1'b1;
        @(negedge clk); chk("proto_clr", 32'(proto_err_o), 0); chk("proto_rst_rvalid", 32'(core_rvalid_o), 0);
        cyc(); rst_i = 1'b0;
        // reset with two requests outstanding
        cyc(); core_req_i = 1'b1; core_addr_i = 32'h0010_0020;
        @(negedge clk); chk("r_gnt0", 32'(core_gnt_o), 1);
        cyc(); @(negedge clk); chk("r_gnt1", 32'(core_gnt_o), 1);
        cyc(); @(negedge clk); chk("r_full", 32'(core_gnt_o), 0);
        cyc(); core_req_i = 1'b0; rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(core_rvalid_o), 0);
        chk("mid_rst_err", 32'(core_err_o), 0);
        chk("mid_rst_nrv", 32'(net_req_valid_o), 0);
        cyc(); rst_i = 1'b0;
        cyc(); resp(32'h0000_0099, 0);
        cyc(); net_resp_valid_i = 1'b0;
        @(negedge clk); chk("post_rst_proto", 32'(proto_err_o), 1); chk("post_rst_drop", 32'(core_rvalid_o), 0);
        cyc(); core_req_i = 1'b1; core_addr_i = 32'h0010_0030;
        @(negedge clk); chk("post_rst_gnt", 32'(core_gnt_o), 1);
        cyc(); core_req_i = 1'b0;
        cyc(); resp(32'h0000_ABCD, 1);
        cyc(); net_resp_valid_i = 1'b0;
        @(negedge clk); chk("post_rst_rvalid", 32'(core_rvalid_o), 1);
        cyc(); cyc();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_data_bridge.md
CORE_DATA_BRIDGE -- requirements
Module: core_data_bridge

Interface
REQ-001 Parameter DataWidth, 32, width of data buses.
REQ-002 Parameter AddrWidth, 32, width of core byte address.
REQ-003 Parameter MaxOutstanding, 2, maximum forwarded requests awaiting response (1..4).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 (clock, all state on rising edge) first, then rst_i input 1 (reset, asserted high, acts without clock).
REQ-005 core_req_i  in  1  core data request.
REQ-006 core_gnt_o  out  1  request accepted this cycle.
REQ-007 core_addr_i  in  AddrWidth  byte address; core_we_i in 1 write; core_be_i in DataWidth/8 byte enables; core_wdata_i in DataWidth write data.
REQ-008 core_rvalid_o  out  1  response valid; core_rdata_o out DataWidth read data; core_err_o out 1 bus error with response.
REQ-009 net_req_valid_o  out  1; net_req_ready_i in 1; net_tgt_addr_o out AddrWidth; net_wen_o out 1; net_be_o out DataWidth/8; net_wdata_o out DataWidth (interconnect host request port).
REQ-010 net_resp_valid_i  in  1; net_resp_ready_o out 1; net_resp_rdata_i in DataWidth (interconnect host response port).
REQ-011 proto_err_o  out  1  sticky flag: response received with nothing outstanding.

Function
REQ-012 Address is mapped iff it falls in RAM (0x00100000, 64 KiB), GPIO (0x80000000, 4 KiB), UART (0x80001000, 4 KiB) or TIMER (0x80002000, 4 KiB), decoded as (addr & MASK) == START.
REQ-013 Mapped request: net_req_valid_o = core_req_i & mapped & (count < MaxOutstanding), combinational; net address/we/be/wdata pass through from core unchanged.
REQ-014 core_gnt_o SHALL equal net_req_valid_o & net_req_ready_i for mapped requests; no grant when count == MaxOutstanding, even if a response arrives in the same cycle.
REQ-015 Outstanding counter count: +1 on forwarded grant, -1 on response accepted with count > 0, unchanged when both occur in the same cycle; never exceeds MaxOutstanding nor underflows.
REQ-016 net_resp_ready_o SHALL be constant 1 (core never back-pressures responses).
REQ-017 Response accepted at cycle N SHALL produce core_rvalid_o=1, core_rdata_o=net_resp_rdata_i (registered), core_err_o=0 at cycle N+1, exactly one cycle wide per response; back-to-back responses give back-to-back rvalid.
REQ-018 Unmapped request: not forwarded; granted only when count == 0 and no error response pending; then core_rvalid_o=1, core_err_o=1, core_rdata_o=0 one cycle after grant.
REQ-019 Unmapped request while count > 0 SHALL stall (gnt=0) until all prior responses delivered, preserving in-order responses.
REQ-020 Response state is a two-state FSM: IDLE (no error pending) -> ERR_RESP on unmapped grant -> IDLE after one cycle; ERR_RESP blocks all grants.
REQ-021 net_resp_valid_i with count == 0 SHALL be dropped (no rvalid) and set proto_err_o until reset.
REQ-022 core_rdata_o SHALL hold its last value when core_rvalid_o=0.

Reset
REQ-023 While rst_i=1: count=0, FSM=IDLE, core_rvalid_o=0, core_err_o=0, core_rdata_o=0, proto_err_o=0; combinational outputs follow from these.
REQ-024 Reset mid-transaction SHALL discard all outstanding state; responses arriving after release with count=0 follow REQ-021.

Structure
REQ-025 Region START/SIZE/MASK constants and region enum SHALL live in shared package pinaipple_pkg, also used by the system top.
REQ-026 Address decode SHALL be a sub-module addr_decoder (combinational: address in, mapped flag and region index out); counter and FSM stay in core_data_bridge.

Verification
REQ-027 Read 0x00100004, ready=1, response 0xDEADBEEF two cycles later -> gnt same cycle, rvalid/rdata=0xDEADBEEF one cycle after response, err=0.
REQ-028 Three reads back-to-back, responses delayed 5 cycles, MaxOutstanding=2 -> first two granted, third gnt=0 until first response accepted, three rvalids in order.
REQ-029 Write 0x90000000 with count=0 -> gnt, next cycle rvalid=1, err=1, rdata=0, net_req_valid_o never asserted.
REQ-030 Read 0x80000000 outstanding, then request to 0x00000000 -> second stalls until GPIO response delivered, then error response follows.
REQ-031 net_resp_valid_i pulse with count=0 -> no rvalid, proto_err_o=1 held; rst_i pulse -> proto_err_o=0.
REQ-032 Assert rst_i with count=2 -> count=0, rvalid=0 immediately, next request granted normally after release.
